// File: rtl/sw_debounce.sv
// Purpose: synchronise and debounce each raw switch bit; emit clean levels plus rise/fall pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from pin change to SW_STABLE and pulse.
// Backpressure: none; free-running, pulses are single-cycle and not held.
module sw_debounce #(
    parameter int   WIDTH           = 4,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 160000,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] SW_RAW,
    output logic [WIDTH-1:0] SW_STABLE,
    output logic [WIDTH-1:0] SW_RISE,
    output logic [WIDTH-1:0] SW_FALL,
    output logic             SW_CHANGED
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_nxt[WIDTH];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;

    assign sync = sync_q[SYNC_STAGES-1];

    // A bit is counting whenever its synchronised level disagrees with the accepted level;
    // any agreeing cycle drops the count so short glitches never reach the terminal value.
    always_comb begin
        stable_nxt = SW_STABLE;
        rise_nxt   = '0;
        fall_nxt   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync[i] != SW_STABLE[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_nxt[i] = sync[i];
                    rise_nxt[i]   = sync[i];
                    fall_nxt[i]   = ~sync[i];
                end else begin
                    cnt_nxt[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= {WIDTH{RESET_LEVEL}};
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            SW_STABLE  <= {WIDTH{RESET_LEVEL}};
            SW_RISE    <= '0;
            SW_FALL    <= '0;
            SW_CHANGED <= 1'b0;
        end else begin
            sync_q[0] <= SW_RAW;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_nxt[i];
            end
            SW_STABLE  <= stable_nxt;
            SW_RISE    <= rise_nxt;
            SW_FALL    <= fall_nxt;
            SW_CHANGED <= |(rise_nxt | fall_nxt);
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=8, SYNC_STAGES=2 (pin-to-output = 10 edges).
module tb_sw_debounce;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] SW_RAW;
    logic [3:0] SW_STABLE;
    logic [3:0] SW_RISE;
    logic [3:0] SW_FALL;
    logic       SW_CHANGED;

    int n_tests = 0;
    int n_fail  = 0;

    sw_debounce #(
        .WIDTH          (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8),
        .RESET_LEVEL    (1'b0)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SW_RAW    (SW_RAW),
        .SW_STABLE (SW_STABLE),
        .SW_RISE   (SW_RISE),
        .SW_FALL   (SW_FALL),
        .SW_CHANGED(SW_CHANGED)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs n edges; outputs hold {before,0,0,0} until edge 'at', show the event there,
    // then hold {after,0,0,0}. at=0 means no event is expected in the window.
    task automatic run_expect(input string name, input int n, input int at,
                              input logic [3:0] st_before, input logic [3:0] st_after,
                              input logic [3:0] rise, input logic [3:0] fall);
        logic [12:0] exp_v;
        for (int k = 1; k <= n; k++) begin
            @(posedge CLK);
            #1;
            if (at == 0 || k < at)
                exp_v = {st_before, 4'h0, 4'h0, 1'b0};
            else if (k == at)
                exp_v = {st_after, rise, fall, |(rise | fall)};
            else
                exp_v = {st_after, 4'h0, 4'h0, 1'b0};
            check($sformatf("%s@%0d {stable,rise,fall,chg}", name, k),
                  {19'd0, SW_STABLE, SW_RISE, SW_FALL, SW_CHANGED}, {19'd0, exp_v});
        end
    endtask

    initial begin
        RST    = 1'b1;
        SW_RAW = 4'hF;
        run_expect("in_reset", 3, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        RST = 1'b0;
        run_expect("rst_release", 12, 10, 4'h0, 4'hF, 4'hF, 4'h0);

        SW_RAW = 4'h0;
        run_expect("all_fall", 12, 10, 4'hF, 4'h0, 4'h0, 4'hF);

        SW_RAW = 4'b0001;
        run_expect("press0", 12, 10, 4'h0, 4'b0001, 4'b0001, 4'h0);

        for (int p = 0; p < 5; p++) begin
            SW_RAW = 4'b0011;
            run_expect($sformatf("bounce_hi%0d", p), 5, 0, 4'b0001, 4'b0001, 4'h0, 4'h0);
            SW_RAW = 4'b0001;
            run_expect($sformatf("bounce_lo%0d", p), 3, 0, 4'b0001, 4'b0001, 4'h0, 4'h0);
        end
        run_expect("bounce_settle", 12, 0, 4'b0001, 4'b0001, 4'h0, 4'h0);

        SW_RAW = 4'b0101;
        run_expect("hold2", 12, 10, 4'b0001, 4'b0101, 4'b0100, 4'h0);
        SW_RAW = 4'b0001;
        run_expect("release2", 12, 10, 4'b0101, 4'b0001, 4'h0, 4'b0100);

        SW_RAW = 4'b0000;
        run_expect("release0", 12, 10, 4'b0001, 4'b0000, 4'h0, 4'b0001);
        SW_RAW = 4'b1001;
        run_expect("simul", 12, 10, 4'b0000, 4'b1001, 4'b1001, 4'h0);
        SW_RAW = 4'b0000;
        run_expect("simul_fall", 12, 10, 4'b1001, 4'b0000, 4'h0, 4'b1001);

        SW_RAW = 4'b1000;
        run_expect("mid_pre", 5, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        RST = 1'b1;
        run_expect("mid_rst", 3, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        RST = 1'b0;
        run_expect("mid_post", 12, 10, 4'h0, 4'b1000, 4'b1000, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
